ethernet_frame_builder: RTL and testbench
=========================================

Name: ethernet_frame_builder

Overview:
- Transmit-side counterpart of the frame parser: takes a payload-only AXI4-Stream plus a per-frame L2 header descriptor and emits a complete Ethernet frame stream with the header prepended.
- Header is the 6B dest MAC, 6B src MAC, an optional 802.1Q tag, and the ethertype.
- Handles the byte realignment caused by the 14B or 18B header on a 64-bit bus.
- Sits between the payload source and the MAC/TX AXIS egress. No FCS, no minimum-size padding: the downstream MAC owns both.

Parameters:
- DATA_WIDTH, 64, stream width in bits; only 64 is supported (8 lanes).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- s_hdr_valid  input  1  header descriptor valid
- s_hdr_ready  output  1  descriptor accepted this cycle
- s_hdr_dest_mac  input  48  destination MAC; [47:40] is the first byte on the wire
- s_hdr_src_mac  input  48  source MAC; same byte order
- s_hdr_ethertype  input  16  inner ethertype; [15:8] is sent first
- s_hdr_vlan_present  input  1  insert 802.1Q tag
- s_hdr_vlan_id  input  12  VID; TCI = {3'b0 PCP, 1'b0 DEI, vlan_id}
- s_axis_tdata  input  64  payload; byte n in tdata[8n+7:8n], lane 0 first
- s_axis_tkeep  input  8  valid lanes; contiguous from lane 0
- s_axis_tvalid  input  1  payload valid
- s_axis_tready  output  1  payload ready
- s_axis_tlast  input  1  last payload beat
- m_axis_tdata  output  64  frame data, same lane order
- m_axis_tkeep  output  8  valid lanes
- m_axis_tvalid  output  1  frame valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last frame beat
- tx_frame_count  output  32  count of frames completed on the m_axis side

Behaviour:
- Reset, synchronous on rst=1:
  - State goes to IDLE.
  - m_axis_tvalid=0, tdata/tkeep/tlast=0.
  - s_hdr_ready=0, s_axis_tready=0.
  - tx_frame_count=0, carry register cleared.
  - Any partial frame is discarded; the next frame starts clean.
- Output register: single stage. It loads when out_ok = !m_axis_tvalid || m_axis_tready.
  - While stalled, tdata/tkeep/tlast are held stable.
  - If a handshake occurs and nothing is loaded that cycle, tvalid drops to 0.
- Header byte stream H:
  - Untagged, 14B: DA[0..5], SA[0..5], ET.
  - Tagged, 18B: DA, SA, 0x81 0x00, TCI[15:8], TCI[7:0], ET.
- Carry offset: R = 6 untagged, R = 2 tagged.
- State IDLE:
  - s_hdr_ready = out_ok.
  - On s_hdr_valid && out_ok:
    - Latch the descriptor.
    - Load H[0..7] into output, keep 0xFF, tlast 0.
    - Carry <= H[8..13] (untagged) or H[16..17] (tagged).
    - Next state is HDR_B if tagged, else PAY.
  - First output beat is valid the cycle after the descriptor is accepted.
- State HDR_B (tagged only): when out_ok, load H[8..15], keep 0xFF, then go to PAY.
- State PAY:
  - s_axis_tready = out_ok. On a payload handshake with n valid bytes:
    - Output = carry (R bytes, lanes 0..R-1) followed by input bytes 0..min(n,8-R)-1.
    - New carry = input bytes 8-R..n-1.
  - On a non-last beat, n must be 8: keep 0xFF, stay in PAY.
  - Last beat with n <= 8-R: keep = R+n low ones, tlast=1, go to IDLE.
  - Last beat with n > 8-R: keep 0xFF, tlast=0, go to FLUSH.
- State FLUSH: when out_ok, output the carry with keep = (n-(8-R)) low ones, tlast=1, go to IDLE.
- s_hdr_ready is 0 outside IDLE. s_axis_tready is 0 outside PAY.
- Every frame needs at least one payload beat; a header with no payload is not supported.
- Non-contiguous tkeep, or tkeep=0, is illegal; output is undefined but the FSM must still return to IDLE on tlast.
- tx_frame_count increments by 1, wrapping at 2^32, on each m_axis handshake with tlast=1.
- Back-to-back frames:
  - The next descriptor is accepted in the first IDLE cycle after the final beat is loaded.
  - That costs one bubble cycle per frame.
  - Steady-state payload throughput is 1 beat/cycle.

Test Plan:
- Untagged frame: DA=001122334455, SA=66778899AABB, ET=0800, payload bytes 00..0F in 2 full beats, keep FF FF. Required output, 4 beats:
  - tdata 0x7766554433221100
  - tdata 0x0100000899BBAA88 is wrong lane order, so check bytes: 88 99 AA BB 08 00 00 01
  - bytes 02..09
  - bytes 0A..0F with keep 0x3F, tlast=1
- Tagged frame, same MACs, VID=0x123, ET=86DD, payload 00..07 in one beat. Required output, 4 beats:
  - DA/SA beat
  - 88 99 AA BB 81 00 01 23
  - 86 DD 00..05, keep FF
  - 06 07, keep 0x03, tlast=1
- Untagged frame, single payload beat with keep 0x03 -> exactly 2 output beats; second beat is 88 99 AA BB 08 00 P0 P1, keep FF, tlast=1; no FLUSH beat.
- Random 50% m_axis_tready over 20 random frames -> output matches the reference model byte for byte; no drop or duplicate; tdata/tkeep/tlast stable while stalled; tx_frame_count=20.
- Descriptors held valid continuously for 3 frames -> s_hdr_ready pulses once per frame, only in IDLE; exactly one idle bubble between frames.
- rst asserted mid-payload -> next cycle m_axis_tvalid=0, s_axis_tready=0, count=0; the following frame is emitted correctly with no stale carry bytes.

Source files
------------

// File: rtl/ethernet_frame_builder.sv
// ethernet_frame_builder: prepends DA/SA/optional 802.1Q tag/ethertype
// to a 64-bit payload AXI4-Stream, realigning payload behind the header.
module ethernet_frame_builder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_hdr_valid,
  output logic                    s_hdr_ready,
  input  logic [47:0]             s_hdr_dest_mac,
  input  logic [47:0]             s_hdr_src_mac,
  input  logic [15:0]             s_hdr_ethertype,
  input  logic                    s_hdr_vlan_present,
  input  logic [11:0]             s_hdr_vlan_id,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [31:0]             tx_frame_count
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR_B,
    PAY,
    FLUSH
  } state_t;

  state_t              state_q;
  logic                tagged_q;
  logic [47:0]         carry_q;
  logic [63:0]         hdr_b_q;
  logic [KEEP_W-1:0]   flush_keep_q;
  logic                m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_W-1:0]   m_keep_q;
  logic                m_last_q;
  logic [31:0]         count_q;

  logic                out_ok;
  logic [15:0]         tci;
  logic [7:0]          hb [18];
  logic [63:0]         hdr_a_d;
  logic [63:0]         hdr_b_d;
  logic [47:0]         hdr_carry_d;
  logic [63:0]         pay_data_d;
  logic [47:0]         pay_carry_d;
  logic                pay_long_d;
  logic [7:0]          pay_keep_d;
  logic [7:0]          flush_keep_d;

  assign out_ok = !m_valid_q || m_axis_tready;
  assign tci    = {4'b0000, s_hdr_vlan_id};

  assign s_hdr_ready   = !rst && (state_q == IDLE) && out_ok;
  assign s_axis_tready = !rst && (state_q == PAY) && out_ok;

  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tkeep   = m_keep_q;
  assign m_axis_tlast   = m_last_q;
  assign tx_frame_count = count_q;

  // Wire-order header bytes built from the live descriptor
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hb[i]     = s_hdr_dest_mac[47-8*i -: 8];
      hb[6 + i] = s_hdr_src_mac[47-8*i -: 8];
    end
    for (int i = 12; i < 18; i++) begin
      hb[i] = 8'h00;
    end
    if (s_hdr_vlan_present) begin
      hb[12] = 8'h81;
      hb[13] = 8'h00;
      hb[14] = tci[15:8];
      hb[15] = tci[7:0];
      hb[16] = s_hdr_ethertype[15:8];
      hb[17] = s_hdr_ethertype[7:0];
    end else begin
      hb[12] = s_hdr_ethertype[15:8];
      hb[13] = s_hdr_ethertype[7:0];
    end
  end

  // Pack header bytes into lanes: first beat, second tagged beat, carry
  always_comb begin
    hdr_a_d     = '0;
    hdr_b_d     = '0;
    hdr_carry_d = '0;
    for (int i = 0; i < 8; i++) begin
      hdr_a_d[8*i +: 8] = hb[i];
      hdr_b_d[8*i +: 8] = hb[8 + i];
    end
    if (s_hdr_vlan_present) begin
      hdr_carry_d[15:0] = {hb[17], hb[16]};
    end else begin
      for (int i = 0; i < 6; i++) begin
        hdr_carry_d[8*i +: 8] = hb[8 + i];
      end
    end
  end

  // Payload realignment: carry fills low lanes, input fills the rest
  always_comb begin
    pay_data_d   = '0;
    pay_carry_d  = '0;
    pay_long_d   = 1'b0;
    pay_keep_d   = '0;
    flush_keep_d = '0;
    if (tagged_q) begin
      pay_data_d   = {s_axis_tdata[47:0], carry_q[15:0]};
      pay_carry_d  = {32'h0, s_axis_tdata[63:48]};
      pay_long_d   = s_axis_tkeep[6];
      pay_keep_d   = {s_axis_tkeep[5:0], 2'b11};
      flush_keep_d = {6'h00, s_axis_tkeep[7:6]};
    end else begin
      pay_data_d   = {s_axis_tdata[15:0], carry_q};
      pay_carry_d  = s_axis_tdata[63:16];
      pay_long_d   = s_axis_tkeep[2];
      pay_keep_d   = {s_axis_tkeep[1:0], 6'h3F};
      flush_keep_d = {2'h0, s_axis_tkeep[7:2]};
    end
  end

  // Frame FSM with the registered output stage and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tagged_q     <= 1'b0;
      carry_q      <= '0;
      hdr_b_q      <= '0;
      flush_keep_q <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      if (m_valid_q && m_axis_tready) begin
        m_valid_q <= 1'b0;
        if (m_last_q) begin
          count_q <= count_q + 32'd1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (s_hdr_valid && out_ok) begin
            tagged_q  <= s_hdr_vlan_present;
            hdr_b_q   <= hdr_b_d;
            carry_q   <= hdr_carry_d;
            m_valid_q <= 1'b1;
            m_data_q  <= hdr_a_d;
            m_keep_q  <= '1;
            m_last_q  <= 1'b0;
            state_q   <= s_hdr_vlan_present ? HDR_B : PAY;
          end
        end
        HDR_B: begin
          if (out_ok) begin
            m_valid_q <= 1'b1;
            m_data_q  <= hdr_b_q;
            m_keep_q  <= '1;
            m_last_q  <= 1'b0;
            state_q   <= PAY;
          end
        end
        PAY: begin
          if (s_axis_tvalid && out_ok) begin
            m_valid_q <= 1'b1;
            m_data_q  <= pay_data_d;
            carry_q   <= pay_carry_d;
            if (!s_axis_tlast) begin
              m_keep_q <= '1;
              m_last_q <= 1'b0;
            end else if (pay_long_d) begin
              m_keep_q     <= '1;
              m_last_q     <= 1'b0;
              flush_keep_q <= flush_keep_d;
              state_q      <= FLUSH;
            end else begin
              m_keep_q <= pay_keep_d;
              m_last_q <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (out_ok) begin
            m_valid_q <= 1'b1;
            m_data_q  <= {16'h0, carry_q};
            m_keep_q  <= flush_keep_q;
            m_last_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_frame_builder.sv
// tb_ethernet_frame_builder: directed and random frames checked beat by
// beat against a byte-queue model of header ++ payload packing.
module tb_ethernet_frame_builder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_hdr_valid;
  logic        s_hdr_ready;
  logic [47:0] s_hdr_dest_mac;
  logic [47:0] s_hdr_src_mac;
  logic [15:0] s_hdr_ethertype;
  logic        s_hdr_vlan_present;
  logic [11:0] s_hdr_vlan_id;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] tx_frame_count;

  ethernet_frame_builder dut (
    .clk                (clk),
    .rst                (rst),
    .s_hdr_valid        (s_hdr_valid),
    .s_hdr_ready        (s_hdr_ready),
    .s_hdr_dest_mac     (s_hdr_dest_mac),
    .s_hdr_src_mac      (s_hdr_src_mac),
    .s_hdr_ethertype    (s_hdr_ethertype),
    .s_hdr_vlan_present (s_hdr_vlan_present),
    .s_hdr_vlan_id      (s_hdr_vlan_id),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .tx_frame_count     (tx_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] et;
    logic        vlan;
    logic [11:0] vid;
  } desc_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef logic [7:0] bq_t[$];

  desc_t hdr_q[$];
  beat_t pay_q[$];
  beat_t exp_q[$];
  int    hdr_acc_cyc[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    rand_ready = 1'b0;
  bit    stall_pend = 1'b0;
  beat_t stall_beat;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_beat(logic [63:0] d, logic [7:0] k, logic l);
    beat_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Queue one frame; optionally derive expected beats from the byte model
  task automatic add_frame(desc_t d, bq_t pl, bit model);
    bq_t fb;
    hdr_q.push_back(d);
    for (int i = 0; i < pl.size(); i += 8) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = '0;
      for (int j = 0; j < 8 && i + j < pl.size(); j++) begin
        b.data[8*j +: 8] = pl[i + j];
        b.keep[j] = 1'b1;
      end
      b.last = (i + 8 >= pl.size());
      pay_q.push_back(b);
    end
    if (model) begin
      fb = {};
      for (int i = 5; i >= 0; i--) fb.push_back(d.da[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fb.push_back(d.sa[8*i +: 8]);
      if (d.vlan) begin
        fb.push_back(8'h81);
        fb.push_back(8'h00);
        fb.push_back({4'h0, d.vid[11:8]});
        fb.push_back(d.vid[7:0]);
      end
      fb.push_back(d.et[15:8]);
      fb.push_back(d.et[7:0]);
      foreach (pl[i]) fb.push_back(pl[i]);
      for (int i = 0; i < fb.size(); i += 8) begin
        beat_t e;
        e.data = '0;
        e.keep = '0;
        for (int j = 0; j < 8 && i + j < fb.size(); j++) begin
          e.data[8*j +: 8] = fb[i + j];
          e.keep[j] = 1'b1;
        end
        e.last = (i + 8 >= fb.size());
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: drive after the edge, sample just before the next edge
  task automatic step();
    beat_t e;
    logic [63:0] mask;
    s_hdr_valid = (hdr_q.size() > 0);
    s_hdr_dest_mac = '0;
    s_hdr_src_mac = '0;
    s_hdr_ethertype = '0;
    s_hdr_vlan_present = 1'b0;
    s_hdr_vlan_id = '0;
    if (hdr_q.size() > 0) begin
      s_hdr_dest_mac = hdr_q[0].da;
      s_hdr_src_mac = hdr_q[0].sa;
      s_hdr_ethertype = hdr_q[0].et;
      s_hdr_vlan_present = hdr_q[0].vlan;
      s_hdr_vlan_id = hdr_q[0].vid;
    end
    s_axis_tvalid = (pay_q.size() > 0);
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    if (pay_q.size() > 0) begin
      s_axis_tdata = pay_q[0].data;
      s_axis_tkeep = pay_q[0].keep;
      s_axis_tlast = pay_q[0].last;
    end
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #8;
    if (!rst) begin
      if (stall_pend) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, stall_beat.data);
        check("stall_keep", m_axis_tkeep, stall_beat.keep);
        check("stall_last", m_axis_tlast, stall_beat.last);
      end
      stall_pend = 1'b0;
      if (m_axis_tvalid && !m_axis_tready) begin
        stall_pend = 1'b1;
        stall_beat.data = m_axis_tdata;
        stall_beat.keep = m_axis_tkeep;
        stall_beat.last = m_axis_tlast;
      end
      if (s_hdr_valid && s_hdr_ready) begin
        void'(hdr_q.pop_front());
        hdr_acc_cyc.push_back(cyc);
      end
      if (s_axis_tvalid && s_axis_tready) void'(pay_q.pop_front());
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          mask = '0;
          for (int j = 0; j < 8; j++) mask[8*j +: 8] = {8{e.keep[j]}};
          check("out_keep", m_axis_tkeep, e.keep);
          check("out_last", m_axis_tlast, e.last);
          check("out_data", m_axis_tdata & mask, e.data & mask);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((exp_q.size() > 0 || pay_q.size() > 0 || hdr_q.size() > 0) &&
           k < budget) begin
      step();
      k++;
    end
    check("drain_left", exp_q.size() + pay_q.size() + hdr_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    desc_t d;
    bq_t   pl;
    int    k;

    rst = 1'b1;
    s_hdr_valid = 1'b0;
    s_hdr_dest_mac = '0;
    s_hdr_src_mac = '0;
    s_hdr_ethertype = '0;
    s_hdr_vlan_present = 1'b0;
    s_hdr_vlan_id = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_hdr_ready", s_hdr_ready, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_count", tx_frame_count, 0);
    rst = 1'b0;

    // Untagged, 16 payload bytes
    d.da = 48'h001122334455;
    d.sa = 48'h66778899AABB;
    d.et = 16'h0800;
    d.vlan = 1'b0;
    d.vid = '0;
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(i));
    add_frame(d, pl, 1'b0);
    exp_beat(64'h7766554433221100, 8'hFF, 1'b0);
    exp_beat(64'h01000008BBAA9988, 8'hFF, 1'b0);
    exp_beat(64'h0908070605040302, 8'hFF, 1'b0);
    exp_beat(64'h00000F0E0D0C0B0A, 8'h3F, 1'b1);
    drain(50);

    // Tagged, VID 0x123, 8 payload bytes
    d.et = 16'h86DD;
    d.vlan = 1'b1;
    d.vid = 12'h123;
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'(i));
    add_frame(d, pl, 1'b0);
    exp_beat(64'h7766554433221100, 8'hFF, 1'b0);
    exp_beat(64'h23010081BBAA9988, 8'hFF, 1'b0);
    exp_beat(64'h050403020100DD86, 8'hFF, 1'b0);
    exp_beat(64'h0000000000000706, 8'h03, 1'b1);
    drain(50);

    // Untagged, 2-byte payload fits without a flush beat
    d.et = 16'h0800;
    d.vlan = 1'b0;
    d.vid = '0;
    pl = {8'hA5, 8'h5A};
    add_frame(d, pl, 1'b0);
    exp_beat(64'h7766554433221100, 8'hFF, 1'b0);
    exp_beat(64'h5AA50008BBAA9988, 8'hFF, 1'b1);
    drain(50);
    check("count_directed", tx_frame_count, 3);

    // Back-to-back descriptors, full-rate sink
    hdr_acc_cyc = {};
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
    add_frame(d, pl, 1'b1);
    d.vlan = 1'b1;
    d.vid = 12'hABC;
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    add_frame(d, pl, 1'b1);
    d.vlan = 1'b0;
    pl = {};
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
    add_frame(d, pl, 1'b1);
    drain(60);
    check("b2b_accepts", hdr_acc_cyc.size(), 3);
    if (hdr_acc_cyc.size() == 3) begin
      check("b2b_gap0", hdr_acc_cyc[1] - hdr_acc_cyc[0], 4);
      check("b2b_gap1", hdr_acc_cyc[2] - hdr_acc_cyc[1], 4);
    end
    check("count_b2b", tx_frame_count, 6);

    // Reset in the middle of a long payload
    pl = {};
    for (int i = 0; i < 40; i++) pl.push_back(8'($urandom));
    add_frame(d, pl, 1'b1);
    k = 0;
    while (pay_q.size() > 3 && k < 40) begin
      step();
      k++;
    end
    check("mid_reached", pay_q.size() <= 3, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hdr_q = {};
    pay_q = {};
    exp_q = {};
    stall_pend = 1'b0;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_s_tready", s_axis_tready, 0);
    check("midrst_count", tx_frame_count, 0);
    d.vlan = 1'b1;
    d.vid = 12'h5A5;
    d.et = 16'h88CC;
    pl = {};
    for (int i = 0; i < 13; i++) pl.push_back(8'($urandom));
    add_frame(d, pl, 1'b1);
    drain(60);
    check("count_post_rst", tx_frame_count, 1);

    // Random frames against a randomly stalling sink
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      d.da = {$urandom, $urandom};
      d.sa = {$urandom, $urandom};
      d.et = 16'($urandom);
      d.vlan = 1'($urandom_range(0, 1));
      d.vid = 12'($urandom);
      pl = {};
      for (int i = 0; i < $urandom_range(1, 40); i++) pl.push_back(8'($urandom));
      add_frame(d, pl, 1'b1);
    end
    drain(3000);
    rand_ready = 1'b0;
    check("count_random", tx_frame_count, 21);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
